// File: rtl/alu_seq.sv
// Multi-cycle execute unit: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier, behind a valid/ready input and a held output register.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = SHW + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Handshake: a transfer happens on a rising clk edge where valid && ready are
  // both high; the producer holds its payload stable while valid is high and
  // ready is low, and ready never depends on the same-side valid.
  logic accept;
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  logic [WIDTH:0]   add_full, sub_full;
  logic             add_ovf, sub_ovf, sub_less;
  logic [SHW-1:0]   shamt;

  assign add_full = {1'b0, src1} + {1'b0, src2};
  assign sub_full = {1'b0, src1} + {1'b0, ~src2} + (WIDTH+1)'(1);
  assign add_ovf  = (src1[WIDTH-1] == src2[WIDTH-1]) && (add_full[WIDTH-1] != src1[WIDTH-1]);
  assign sub_ovf  = (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_full[WIDTH-1] != src1[WIDTH-1]);
  assign sub_less = sub_full[WIDTH-1] ^ sub_ovf;
  assign shamt    = src2[SHW-1:0];

  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf, alu_known, alu_zero;

  always_comb begin
    alu_res   = '0;
    alu_cout  = 1'b0;
    alu_ovf   = 1'b0;
    alu_known = 1'b1;
    case (ALU_control)
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_NOR:  alu_res = ~(src1 | src2);
      OP_NAND: alu_res = ~(src1 & src2);
      OP_ADD: begin
        alu_res  = add_full[WIDTH-1:0];
        alu_cout = add_full[WIDTH];
        alu_ovf  = add_ovf;
      end
      OP_SUB: begin
        alu_res  = sub_full[WIDTH-1:0];
        alu_cout = sub_full[WIDTH];
        alu_ovf  = sub_ovf;
      end
      OP_SLT: begin
        alu_res  = {{(WIDTH-1){1'b0}}, sub_less};
        alu_cout = sub_full[WIDTH];
      end
      OP_SLL:  alu_res = src1 << shamt;
      OP_SRL:  alu_res = src1 >> shamt;
      OP_SRA:  alu_res = $signed(src1) >>> shamt;
      default: alu_known = 1'b0;
    endcase
  end

  // Unknown opcodes report zero = 0 even though their result is 0.
  assign alu_zero = alu_known && (alu_res == '0);

  // One multiplier step: conditional add into the upper half, then the
  // {carry, acc, mplier} chain shifts right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  assign mul_sum   = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], mplier_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (ALU_control == OP_MUL) begin
            mcand_d  = src1;
            mplier_d = src2;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = alu_zero;
            cout_d      = alu_cout;
            ovf_d       = alu_ovf;
            state_d     = S_DONE;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = mul_hi_nx;
        mplier_d = mul_lo_nx;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cnt_d       = '0;
          result_d    = mul_lo_nx;
          result_hi_d = mul_hi_nx;
          zero_d      = (mul_lo_nx == '0);
          cout_d      = 1'b0;
          ovf_d       = (mul_hi_nx != '0);
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign zero        = zero_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

  a_mul_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_MUL) |-> !in_ready);
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_MUL) |-> (cnt_q <= LAST_CNT));
  a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(result) && $stable(result_hi)));

endmodule
